// File: rtl/johnson_decoder.sv
// Johnson-code decoder with sequence tracking: decodes q_in to an index,
// locks after LOCK_COUNT consecutive correct steps and counts sequence errors.
//
// state    | meaning
// UNLOCKED | no legal reference sample yet, or last sample illegal
// ACQUIRE  | have a legal reference, counting correct steps toward lock
// LOCKED   | sequence tracked; any wrong or illegal sample is an error
module johnson_decoder #(
    parameter  int WIDTH      = 4,
    parameter  int LOCK_COUNT = 3,
    localparam int N          = 2 * WIDTH,
    localparam int IDX_W      = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] q_in,
    output logic [IDX_W-1:0] state_idx,
    output logic [N-1:0]     onehot,
    output logic             code_valid,
    output logic             locked,
    output logic             seq_err,
    output logic [7:0]       err_count
);

    localparam int RUN_W = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {
        UNLOCKED,
        ACQUIRE,
        LOCKED
    } state_t;

    state_t           state_q, state_nx;
    logic [RUN_W-1:0] run_q, run_nx;
    logic [RUN_W:0]   run_inc;
    logic             err_nx;
    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic [IDX_W-1:0] idx_succ;
    logic             step_ok;
    logic [WIDTH-1:0] code;

    // Walk the legal sequence from all-zero and match the sample against each code.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        code    = '0;
        for (int k = 0; k < N; k++) begin
            if (!hit && q_in == code) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(k);
            end
            code = {code[WIDTH-2:0], ~code[WIDTH-1]};
        end
    end

    assign idx_succ = (state_idx == IDX_W'(N - 1)) ? '0 : state_idx + 1'b1;
    assign step_ok  = hit && (hit_idx == idx_succ);
    assign run_inc  = {1'b0, run_q} + 1'b1;

    always_comb begin
        state_nx = state_q;
        run_nx   = run_q;
        err_nx   = 1'b0;
        if (en) begin
            unique case (state_q)
                UNLOCKED: begin
                    if (hit) begin
                        state_nx = ACQUIRE;
                        run_nx   = '0;
                    end
                end
                ACQUIRE: begin
                    if (!hit) begin
                        state_nx = UNLOCKED;
                        run_nx   = '0;
                    end else if (step_ok) begin
                        run_nx = run_inc[RUN_W-1:0];
                        if (run_inc >= (RUN_W+1)'(LOCK_COUNT)) state_nx = LOCKED;
                    end else begin
                        run_nx = '0;
                    end
                end
                LOCKED: begin
                    if (!hit) begin
                        state_nx = UNLOCKED;
                        run_nx   = '0;
                        err_nx   = 1'b1;
                    end else if (!step_ok) begin
                        state_nx = ACQUIRE;
                        run_nx   = '0;
                        err_nx   = 1'b1;
                    end
                end
                default: begin
                    state_nx = UNLOCKED;
                    run_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= UNLOCKED;
            run_q      <= '0;
            state_idx  <= '0;
            onehot     <= '0;
            code_valid <= 1'b0;
            locked     <= 1'b0;
            seq_err    <= 1'b0;
            err_count  <= '0;
        end else begin
            state_q <= state_nx;
            run_q   <= run_nx;
            locked  <= (state_nx == LOCKED);
            seq_err <= err_nx;
            if (err_nx && err_count != 8'hFF) err_count <= err_count + 8'd1;
            if (en) begin
                code_valid <= hit;
                onehot     <= hit ? (N'(1) << hit_idx) : '0;
                if (hit) state_idx <= hit_idx;
            end
        end
    end

endmodule

// File: tb/tb_johnson_decoder.sv
// Self-checking bench for johnson_decoder: a behavioural model is compared on
// every falling edge, with literal expectations pinning the directed scenarios.
module tb_johnson_decoder;

    localparam int W  = 4;
    localparam int N  = 2 * W;
    localparam int LC = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic [W-1:0] q_in;
    logic [2:0]   state_idx;
    logic [N-1:0] onehot;
    logic         code_valid, locked, seq_err;
    logic [7:0]   err_count;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    johnson_decoder #(.WIDTH(W), .LOCK_COUNT(LC)) dut (
        .clk(clk), .reset(reset), .en(en), .q_in(q_in),
        .state_idx(state_idx), .onehot(onehot), .code_valid(code_valid),
        .locked(locked), .seq_err(seq_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Code k: k ones from the bottom for k<=W, then ones drain out of the bottom.
    function automatic logic [W-1:0] code_of(int k);
        int full, v;
        full = (1 << W) - 1;
        if (k <= W) v = (1 << k) - 1;
        else        v = full & ~((1 << (k - W)) - 1);
        return W'(v);
    endfunction

    function automatic int idx_of(logic [W-1:0] q);
        for (int k = 0; k < N; k++) if (code_of(k) == q) return k;
        return -1;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // mode: 0 unlocked, 1 acquiring, 2 locked
    int m_mode = 0, m_run = 0, m_idx = 0, m_err = 0;
    bit m_valid = 0, m_seqerr = 0;
    int mk;
    bit mgood;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode <= 0; m_run <= 0; m_idx <= 0; m_err <= 0;
            m_valid <= 0; m_seqerr <= 0;
        end else begin
            m_seqerr <= 0;
            if (en) begin
                mk    = idx_of(q_in);
                mgood = (mk >= 0) && (mk == (m_idx + 1) % N);
                if (mk < 0) begin
                    m_valid <= 0;
                    if (m_mode == 2) begin
                        m_seqerr <= 1;
                        if (m_err < 255) m_err <= m_err + 1;
                    end
                    m_mode <= 0;
                    m_run  <= 0;
                end else begin
                    m_valid <= 1;
                    m_idx   <= mk;
                    if (m_mode == 0) begin
                        m_mode <= 1; m_run <= 0;
                    end else if (m_mode == 1) begin
                        if (mgood) begin
                            m_run <= m_run + 1;
                            if (m_run + 1 >= LC) m_mode <= 2;
                        end else m_run <= 0;
                    end else if (!mgood) begin
                        m_mode <= 1; m_run <= 0; m_seqerr <= 1;
                        if (m_err < 255) m_err <= m_err + 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("state_idx", int'(state_idx), m_idx);
            chk("onehot", int'(onehot), m_valid ? (1 << m_idx) : 0);
            chk("code_valid", int'(code_valid), int'(m_valid));
            chk("locked", int'(locked), (m_mode == 2) ? 1 : 0);
            chk("seq_err", int'(seq_err), int'(m_seqerr));
            chk("err_count", int'(err_count), m_err);
        end
    end

    task automatic step(bit e, logic [W-1:0] q);
        en = e;
        q_in = q;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, "_idx"}, int'(state_idx), 0);
        chk({tag, "_onehot"}, int'(onehot), 0);
        chk({tag, "_valid"}, int'(code_valid), 0);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_seq_err"}, int'(seq_err), 0);
        chk({tag, "_err_count"}, int'(err_count), 0);
    endtask

    int cur;

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        q_in  = '0;
        #1 reset = 1'b0;
        #1 check_all_zero("rst");
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        chk_on = 1'b1;

        // acquire and lock
        step(1, 4'b0000);
        chk("first_onehot", int'(onehot), 8'h01);
        chk("first_seq_err", int'(seq_err), 0);
        step(1, 4'b0001);
        step(1, 4'b0011);
        chk("pre_lock", int'(locked), 0);
        step(1, 4'b0111);
        chk("lock", int'(locked), 1);
        chk("lock_idx", int'(state_idx), 3);

        // advance through the wrap
        step(1, 4'b1111);
        step(1, 4'b1110);
        step(1, 4'b1100);
        step(1, 4'b1000);
        chk("idx7", int'(state_idx), 7);
        chk("idx7_onehot", int'(onehot), 8'h80);
        step(1, 4'b0000);
        chk("wrap_idx", int'(state_idx), 0);
        chk("wrap_locked", int'(locked), 1);
        chk("wrap_seq_err", int'(seq_err), 0);

        // legal skip while locked
        step(1, 4'b0001);
        step(1, 4'b0011);
        step(1, 4'b1111);
        chk("skip_seq_err", int'(seq_err), 1);
        chk("skip_err_count", int'(err_count), 1);
        chk("skip_locked", int'(locked), 0);
        step(1, 4'b1110);
        chk("skip_pulse_width", int'(seq_err), 0);
        step(1, 4'b1100);
        chk("reacq_not_yet", int'(locked), 0);
        step(1, 4'b1000);
        chk("reacq_locked", int'(locked), 1);
        step(1, 4'b0000);

        // illegal code while locked
        step(1, 4'b0101);
        chk("illegal_valid", int'(code_valid), 0);
        chk("illegal_onehot", int'(onehot), 0);
        chk("illegal_idx_held", int'(state_idx), 0);
        chk("illegal_seq_err", int'(seq_err), 1);
        chk("illegal_locked", int'(locked), 0);
        chk("illegal_err_count", int'(err_count), 2);

        // en gating, then a repeated code
        for (int k = 0; k < 4; k++) step(1, code_of(k));
        chk("relock", int'(locked), 1);
        step(1, 4'b1111);
        step(0, 4'b1110);
        chk("hold_idx", int'(state_idx), 4);
        chk("hold_seq_err", int'(seq_err), 0);
        chk("hold_locked", int'(locked), 1);
        step(1, 4'b1110);
        step(0, 4'b1001);
        chk("hold_valid", int'(code_valid), 1);
        step(1, 4'b1100);
        step(1, 4'b1100);
        chk("repeat_seq_err", int'(seq_err), 1);
        chk("repeat_err_count", int'(err_count), 3);

        // saturate the error counter
        cur = 6;
        for (int i = 0; i < 260; i++) begin
            for (int s = 0; s < 3; s++) begin
                cur = (cur + 1) % N;
                step(1, code_of(cur));
            end
            step(1, code_of(cur));
        end
        chk("sat_err_count", int'(err_count), 255);
        for (int s = 0; s < 3; s++) begin
            cur = (cur + 1) % N;
            step(1, code_of(cur));
        end
        step(1, code_of(cur));
        chk("sat_hold", int'(err_count), 255);

        // asynchronous reset mid-stream
        step(1, code_of((cur + 1) % N));
        #2 reset = 1'b0;
        #1 check_all_zero("async");
        @(posedge clk);
        #1 reset = 1'b1;
        step(1, 4'b0000);
        chk("post_rst_seq_err", int'(seq_err), 0);
        chk("post_rst_locked", int'(locked), 0);
        step(1, 4'b0001);
        step(1, 4'b0011);
        step(1, 4'b0111);
        chk("post_rst_relock", int'(locked), 1);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/johnson_decoder.md
JOHNSON_DECODER -- requirements
Module: johnson_decoder

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the Johnson code width; the sequence length is N = 2*WIDTH states.
REQ-002 Parameter LOCK_COUNT, default 3, SHALL set the number of consecutive correct steps required to assert lock.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-low reset (0 = reset asserted).
REQ-005 en  input  1  SHALL be the sample strobe; q_in is evaluated only on cycles with en=1.
REQ-006 q_in  input  WIDTH  SHALL be the Johnson code under decode.
REQ-007 state_idx  output  clog2(N) (3 for default)  SHALL give the decoded index of the last legal sample.
REQ-008 onehot  output  N (8 for default)  SHALL be the one-hot form of state_idx, or all-zero when the last sample was illegal.
REQ-009 code_valid  output  1  SHALL be high when the last sampled code was legal.
REQ-010 locked  output  1  SHALL be high while the FSM is in LOCKED.
REQ-011 seq_err  output  1  SHALL pulse for one cycle on each error detected while LOCKED.
REQ-012 err_count  output  8  SHALL be a saturating count of seq_err pulses.

Function
REQ-013 The legal sequence SHALL follow the next-state rule next = {q[WIDTH-2:0], ~q[WIDTH-1]}, starting from all-zero; for WIDTH=4: 0000=0, 0001=1, 0011=2, 0111=3, 1111=4, 1110=5, 1100=6, 1000=7, after which the sequence wraps to 0.
REQ-014 Any code outside the N legal codes (e.g. 0101, 1001) SHALL be classified as illegal.
REQ-015 All outputs SHALL be registered, with a latency of exactly 1 cycle from the sampled edge (en=1) to the output update.
REQ-016 On en=0 cycles, state_idx, onehot, code_valid, locked, the FSM state and the run counter SHALL hold; seq_err SHALL be 0.
REQ-017 On an illegal sample: code_valid=0, onehot=0, and state_idx SHALL hold its previous value.
REQ-018 A step SHALL be correct when the sample is legal and idx == (prev_idx+1) mod N, where prev_idx is the index of the previous legal sample; a repeated code counts as a wrong step.
REQ-019 The FSM SHALL have three states: UNLOCKED, ACQUIRE, LOCKED.
REQ-020 UNLOCKED: a legal sample SHALL move the FSM to ACQUIRE with run=0; an illegal sample SHALL keep it in UNLOCKED.
REQ-021 ACQUIRE, correct step: run SHALL increment; when run reaches LOCK_COUNT, the FSM SHALL move to LOCKED and locked=1 on the same output update.
REQ-022 ACQUIRE, legal wrong step: the FSM SHALL stay in ACQUIRE with run=0 and the new index as reference. ACQUIRE, illegal sample: the FSM SHALL move to UNLOCKED.
REQ-023 LOCKED, correct step: the FSM SHALL stay in LOCKED. Wrap-around from N-1 to 0 is a correct step.
REQ-024 LOCKED, legal wrong step: seq_err SHALL pulse and the FSM SHALL move to ACQUIRE (run=0). LOCKED, illegal sample: seq_err SHALL pulse and the FSM SHALL move to UNLOCKED.
REQ-025 err_count SHALL increment on each seq_err pulse and saturate at 255 without wrapping.
REQ-026 seq_err SHALL never assert in UNLOCKED or ACQUIRE.

Reset
REQ-027 While reset=0, regardless of clk: FSM=UNLOCKED, run=0, state_idx=0, onehot=0, code_valid=0, locked=0, seq_err=0, err_count=0.
REQ-028 Reset asserted mid-operation SHALL clear all state immediately; after release, lock SHALL be reacquired from scratch.
REQ-029 The first rising edge after reset deasserts SHALL be treated as a normal cycle, with no spurious seq_err.

Verification
REQ-030 Reset, then en=1 with the sequence 0000,0001,0011,0111 -> onehot 00000001 one cycle after the first sample; locked=1 one cycle after 0111 is sampled; seq_err=0 throughout.
REQ-031 Locked, feed 1000 then 0000 -> state_idx 7 then 0; locked stays 1; seq_err=0 (wrap-around).
REQ-032 Locked at idx 2, feed 1111 (idx 4) -> seq_err=1 for one cycle; err_count +1; locked=0; FSM in ACQUIRE; three further correct steps -> locked=1.
REQ-033 Locked, feed 0101 -> code_valid=0, onehot=0, state_idx held, seq_err pulse, locked=0, FSM in UNLOCKED.
REQ-034 Locked, alternate en=1/0 while advancing codes -> outputs hold on en=0 cycles; no seq_err; a repeated code with en=1 -> seq_err.
REQ-035 Force 260 locked-state errors -> err_count=255 and holds; pull reset low mid-stream -> all outputs 0 without waiting for a clock edge.
